// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write bus of the boot image loader
interface imem_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, im_we, im_addr, im_wdata, cpu_hold, done, err
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, im_we, im_addr, im_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - receives a framed, checksummed boot image and writes it into instruction memory
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    imem_loader_if.master  bus
);
    localparam logic [7:0]  HEADER    = 8'hA5;
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        len_hi;
    logic [15:0]       word_cnt;
    logic [16:0]       word_idx;
    logic [1:0]        byte_cnt;
    logic [31:0]       asm_word;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] im_addr_q;
    logic [31:0]       im_wdata_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic [16:0]       len_full;
    logic              last_word;
    logic              start;
    logic              len_bad;
    logic              csum_ok;
    logic              csum_bad;

    assign accept    = bus.rx_valid && (state != WRITE);
    assign len_full  = {1'b0, len_hi, bus.rx_data};
    // 17-bit compare so a count of exactly 2**ADDR_W terminates without wrapping
    assign last_word = (word_idx + 17'd1) == {1'b0, word_cnt};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        len_bad   = 1'b0;
        csum_ok   = 1'b0;
        csum_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && bus.rx_data == HEADER) begin
                    state_nxt = LEN_HI;
                    start     = 1'b1;
                end
            end
            LEN_HI: begin
                if (accept) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    if (len_full > MAX_WORDS) begin
                        len_bad   = 1'b1;
                        state_nxt = IDLE;
                    end else if (len_full == 17'd0) begin
                        state_nxt = CSUM;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (accept && byte_cnt == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                state_nxt = last_word ? CSUM : DATA;
            end
            CSUM: begin
                if (accept) begin
                    state_nxt = IDLE;
                    if (bus.rx_data == csum) csum_ok  = 1'b1;
                    else                     csum_bad = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_hi     <= '0;
            word_cnt   <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            asm_word   <= '0;
            csum       <= '0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= csum_ok;
            if (start) begin
                cpu_hold_q <= 1'b1;
                err_q      <= 1'b0;
                word_idx   <= '0;
                csum       <= '0;
                byte_cnt   <= '0;
            end
            if (state == LEN_HI && accept) len_hi   <= bus.rx_data;
            if (state == LEN_LO && accept) word_cnt <= {len_hi, bus.rx_data};
            if (len_bad || csum_bad) err_q <= 1'b1;
            if (csum_ok) cpu_hold_q <= 1'b0;
            if (state == DATA && accept) begin
                asm_word <= {asm_word[23:0], bus.rx_data};
                csum     <= csum + bus.rx_data;
                byte_cnt <= byte_cnt + 2'd1;
                // Address and word are latched here so they hold after the WRITE cycle
                if (byte_cnt == 2'd3) begin
                    im_addr_q  <= word_idx[ADDR_W-1:0];
                    im_wdata_q <= {asm_word[23:0], bus.rx_data};
                end
            end
            if (state == WRITE) word_idx <= word_idx + 17'd1;
        end
    end

    assign bus.rx_ready = (state != WRITE);
    assign bus.im_we    = (state == WRITE);
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign bus.cpu_hold = cpu_hold_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a frame-parsing reference model
module tb_imem_loader;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
    imem_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  hist[$];
    logic [7:0]  tx[$];
    logic [39:0] got_q[$];
    logic [39:0] exp_q[$];
    int          done_seen = 0;
    int          ready_in_write = 0;
    bit          gaps = 0;

    always @(negedge clk) begin
        if (!rst) begin
            got_q.delete();
            done_seen      = 0;
            ready_in_write = 0;
        end else begin
            if (bus.im_we) begin
                got_q.push_back({bus.im_addr, bus.im_wdata});
                if (bus.rx_ready) ready_in_write++;
            end
            if (bus.done) done_seen++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Parses the whole byte history since reset as frames and derives the expected effects
    function automatic void model(output int dn, output bit e, output bit h);
        int         i;
        int         n;
        logic [7:0] sum;
        logic [31:0] w;
        bit         stop;
        exp_q.delete();
        dn = 0; e = 0; h = 1; i = 0; stop = 0;
        while (!stop && i < hist.size()) begin
            if (hist[i] !== 8'hA5) begin
                i++;
            end else begin
                i++; e = 0; h = 1;
                if (i + 2 > hist.size()) begin
                    stop = 1;
                end else begin
                    n = int'(hist[i]) * 256 + int'(hist[i+1]);
                    i += 2;
                    if (n > (1 << ADDR_W)) begin
                        e = 1;
                    end else begin
                        sum = 8'd0;
                        for (int k = 0; k < n && !stop; k++) begin
                            if (i + 4 > hist.size()) begin
                                stop = 1;
                            end else begin
                                w   = {hist[i], hist[i+1], hist[i+2], hist[i+3]};
                                sum = sum + hist[i] + hist[i+1] + hist[i+2] + hist[i+3];
                                exp_q.push_back({k[7:0], w});
                                i += 4;
                            end
                        end
                        if (!stop) begin
                            if (i >= hist.size()) begin
                                stop = 1;
                            end else begin
                                if (hist[i] == sum) begin dn++; h = 0; end
                                else e = 1;
                                i++;
                            end
                        end
                    end
                end
            end
        end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int t;
        int g;
        if (gaps) begin
            g = $urandom_range(0, 3);
            repeat (g) begin
                @(negedge clk);
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t = 0;
        while (!bus.rx_ready && t < 8) begin
            @(negedge clk);
            t++;
        end
        if (t >= 8) begin
            n_cmp++;
            n_bad++;
            $error("FAIL ready_timeout: observed rx_ready 0 expected 1");
        end else begin
            hist.push_back(b);
        end
        @(posedge clk);
    endtask

    task automatic send_tx();
        foreach (tx[i]) send_byte(tx[i]);
        tx.delete();
    endtask

    task automatic settle();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        int dn;
        bit e;
        bit h;
        model(dn, e, h);
        check($sformatf("%s/nwrites", tag), 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s/write%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        check($sformatf("%s/done_cnt", tag), 64'(done_seen), 64'(dn));
        check($sformatf("%s/err", tag), 64'(bus.err), 64'(e));
        check($sformatf("%s/cpu_hold", tag), 64'(bus.cpu_hold), 64'(h));
        check($sformatf("%s/rx_ready_idle", tag), 64'(bus.rx_ready), 64'(1));
        check($sformatf("%s/ready_in_write", tag), 64'(ready_in_write), 64'(0));
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        repeat (n) @(negedge clk);
        check("rst/im_we", 64'(bus.im_we), 64'(0));
        check("rst/im_addr", 64'(bus.im_addr), 64'(0));
        check("rst/im_wdata", 64'(bus.im_wdata), 64'(0));
        check("rst/cpu_hold", 64'(bus.cpu_hold), 64'(1));
        check("rst/done", 64'(bus.done), 64'(0));
        check("rst/err", 64'(bus.err), 64'(0));
        hist.delete();
        rst = 1'b1;
        @(negedge clk);
        check("rst/rx_ready", 64'(bus.rx_ready), 64'(1));
    endtask

    task automatic push_good_frame();
        tx.push_back(8'hA5); tx.push_back(8'h00); tx.push_back(8'h02);
        tx.push_back(8'h11); tx.push_back(8'h22); tx.push_back(8'h33); tx.push_back(8'h44);
        tx.push_back(8'h55); tx.push_back(8'h66); tx.push_back(8'h77); tx.push_back(8'h88);
    endtask

    initial begin
        logic [7:0] sum;
        logic [7:0] b;
        int         n;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        do_reset(3);

        push_good_frame(); tx.push_back(8'h64);
        send_tx(); settle();
        check_all("good");
        check("good/word0", 64'(got_q.size() > 0 ? got_q[0] : 40'h0), 64'(40'h00_11223344));
        check("good/word1", 64'(got_q.size() > 1 ? got_q[1] : 40'h0), 64'(40'h01_55667788));
        check("good/cpu_hold", 64'(bus.cpu_hold), 64'(0));

        push_good_frame(); tx.push_back(8'h65);
        send_tx(); settle();
        check_all("badcsum");
        check("badcsum/err", 64'(bus.err), 64'(1));

        tx.push_back(8'hA5);
        send_tx(); settle();
        check_all("hdr_clears_err");
        check("hdr_clears_err/err", 64'(bus.err), 64'(0));
        push_good_frame(); void'(tx.pop_front()); tx.push_back(8'h64);
        send_tx(); settle();
        check_all("good_after_bad");

        tx = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_tx(); settle();
        check_all("zero_len");

        tx = '{8'hA5, 8'h01, 8'h01};
        send_tx(); settle();
        check_all("oversize");
        check("oversize/err", 64'(bus.err), 64'(1));
        tx = '{8'h3C, 8'h00, 8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        tx.push_back(8'(8'hDE + 8'hAD + 8'hBE + 8'hEF));
        send_tx(); settle();
        check_all("noise_then_frame");

        tx = '{8'hA5, 8'h01, 8'h00};
        sum = 8'd0;
        for (int i = 0; i < 1024; i++) begin
            b = 8'($urandom);
            sum = sum + b;
            tx.push_back(b);
        end
        tx.push_back(sum);
        send_tx(); settle();
        check_all("full_image");

        tx = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_tx(); settle();
        check_all("pre_reset");
        do_reset(2);
        repeat (6) @(negedge clk);
        check_all("after_reset");

        gaps = 1;
        push_good_frame(); tx.push_back(8'h64);
        send_tx(); settle();
        check_all("good_with_gaps");

        for (int f = 0; f < 12; f++) begin
            gaps = bit'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                tx.push_back(b);
            end
            n = ($urandom_range(0, 7) == 0) ? 257 + $urandom_range(0, 40) : $urandom_range(0, 5);
            tx.push_back(8'hA5);
            tx.push_back(8'(n >> 8));
            tx.push_back(8'(n));
            if (n <= 256) begin
                sum = 8'd0;
                for (int i = 0; i < 4 * n; i++) begin
                    b = 8'($urandom);
                    sum = sum + b;
                    tx.push_back(b);
                end
                if ($urandom_range(0, 2) == 0) sum = sum + 8'($urandom_range(1, 255));
                tx.push_back(sum);
            end
            send_tx(); settle();
            check_all($sformatf("rand%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
